// File: rtl/imgproc_writeback.sv
// rtl/imgproc_writeback.sv - imgproc pixel writeback: {addr,data} FIFO to result SRAM with frame FSM
//   Optional feature macro: WRITEBACK_CHECKSUM_EN (adds 16-bit checksum output of written data)
module imgproc_writeback #(
    parameter int DEPTH = 8,      // FIFO entries, power of two, at least 2
    parameter int AW    = 14,     // pixel address width
    parameter int DW    = 8,      // pixel data width
    parameter int NPIX  = 16384   // pixels per frame
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imgproc_ready,
    input  logic [AW-1:0] imgproc_addr,
    input  logic [DW-1:0] imgproc_data,
    input  logic          finish,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ack,
    output logic [AW:0]   pix_cnt,
    output logic          overflow,
`ifdef WRITEBACK_CHECKSUM_EN
    output logic [15:0]   checksum,
`endif
    output logic          done
);

    localparam int          PW     = $clog2(DEPTH);
    localparam int          EW     = AW + DW;
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);
    localparam logic [AW:0] NPIX_C = (AW+1)'(NPIX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q;
    logic            done_q;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW:0]     count_q, count_d;
    logic [AW:0]     pix_cnt_q, pix_cnt_d;
    logic            overflow_q, overflow_d;

    logic            accepting;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push_req;
    logic            push;
    logic            drop;
    logic [EW-1:0]   head;

    // Pushes are only taken before finish; a full FIFO still accepts when
    // the head leaves on the same edge, so occupancy stays at DEPTH.
    assign accepting = (state_q == S_IDLE) || (state_q == S_RUN);
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_C);
    assign pop       = !empty && wr_ack;
    assign push_req  = accepting && imgproc_ready;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // Head entry drives the SRAM port directly; zeros when nothing is queued
    // so stale storage never shows after reset.
    assign head    = mem_q[rptr_q];
    assign wr_en   = !empty;
    assign wr_addr = empty ? '0 : head[EW-1:DW];
    assign wr_data = empty ? '0 : head[DW-1:0];

    assign pix_cnt  = pix_cnt_q;
    assign overflow = overflow_q;
    assign done     = done_q;

    // Next-state for pointers, occupancy, write counter and sticky drop flag.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        pix_cnt_d  = pix_cnt_q;
        overflow_d = overflow_q | drop;

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            if (pix_cnt_q < NPIX_C) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy, counter and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            pix_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            pix_cnt_q  <= pix_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {imgproc_addr, imgproc_data};
        end
    end

    // Frame FSM with registered done: finish wins over the IDLE->RUN move,
    // and DONE is entered on the first edge that sees the FIFO empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (finish) begin
                        state_q <= S_FLUSH;
                    end else if (imgproc_ready) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (finish) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (empty) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WRITEBACK_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Running modulo-2^16 sum of every pixel value written; frozen once DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else if (pop && (state_q != S_DONE)) begin
            checksum_q <= checksum_q + 16'(wr_data);
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
